// File: rtl/popcount_pkg.sv
// Shared types and constants for the sequential population-count engine.
package popcount_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bits consumed per compute cycle.
    localparam int LUT_W = 4;

    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/popcount_nib4.sv
// Combinational ones count of a single nibble (0..4).
module popcount_nib4 (
    input  logic [3:0] nib_i,
    output logic [2:0] cnt_o
);

    always_comb begin
        cnt_o = 3'd0;
        unique case (nib_i)
            4'h0:                                      cnt_o = 3'd0;
            4'h1, 4'h2, 4'h4, 4'h8:                    cnt_o = 3'd1;
            4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC:        cnt_o = 3'd2;
            4'h7, 4'hB, 4'hD, 4'hE:                    cnt_o = 3'd3;
            4'hF:                                      cnt_o = 3'd4;
            default:                                   cnt_o = 3'd0;
        endcase
    end

endmodule

// File: rtl/popcount_seq.sv
// Multi-cycle ones/zeros counter: one nibble per cycle, result plus threshold flag
// returned over a valid/ready handshake.
module popcount_seq
    import popcount_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int NIB   = WIDTH / LUT_W,
    localparam int CW    = count_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic [CW-1:0]    in_thresh,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             out_ge,
    output logic             busy
);

    localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // ready/valid here decode from state only, never from the partner's signal.
    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    thr_q, thr_d;
    logic [CW-1:0]    acc_q, acc_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ge_q, ge_d;
    logic [2:0]       nib_cnt;
    logic [CW-1:0]    sum;

    popcount_nib4 u_nib (
        .nib_i (shreg_q[LUT_W-1:0]),
        .cnt_o (nib_cnt)
    );

    assign sum       = acc_q + CW'(nib_cnt);
    assign in_ready  = ~rst && (state_q == IDLE);
    assign out_valid = ~rst && (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_count = count_q;
    assign out_ge    = ge_q;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        thr_d   = thr_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        count_d = count_q;
        ge_d    = ge_q;
        unique case (state_q)
            IDLE: begin
                // Counting zeros is counting ones of the inverted word.
                if (in_valid && in_ready) begin
                    shreg_d = in_mode ? ~in_data : in_data;
                    thr_d   = in_thresh;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = sum;
                shreg_d = shreg_q >> LUT_W;
                idx_d   = idx_q + IW'(1);
                if (idx_q == IW'(NIB - 1)) begin
                    count_d = sum;
                    ge_d    = (sum >= thr_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            thr_q   <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
            ge_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            thr_q   <= thr_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            ge_q    <= ge_d;
        end
    end

endmodule

// File: tb/tb_popcount_seq.sv
// Scoreboard bench for popcount_seq: a WIDTH=32 instance for directed/stream tests
// and a WIDTH=4 instance swept exhaustively.
`timescale 1ns/1ps
module tb_popcount_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_miss = 0;

    // WIDTH=32 instance
    logic        a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_ge, a_busy;
    logic [31:0] a_in_data;
    logic [5:0]  a_in_thresh, a_out_count;

    // WIDTH=4 instance
    logic        b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_ge, b_busy;
    logic [3:0]  b_in_data;
    logic [2:0]  b_in_thresh, b_out_count;

    popcount_seq #(.WIDTH(32)) u_dut32 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_mode   (a_in_mode),
        .in_thresh (a_in_thresh),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_count (a_out_count),
        .out_ge    (a_out_ge),
        .busy      (a_busy)
    );

    popcount_seq #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_mode   (b_in_mode),
        .in_thresh (b_in_thresh),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_count (b_out_count),
        .out_ge    (b_out_ge),
        .busy      (b_busy)
    );

    // Expected results: {count, ge}
    logic [6:0] exp_a[$];
    logic [3:0] exp_b[$];
    int acc_cyc_a = 0;
    int acc_cyc_b = 0;
    bit ov_prev_a = 1'b0;
    bit ov_prev_b = 1'b0;
    bit stream_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for the 32-bit instance
    always @(negedge clk) begin
        logic [6:0] e;
        if (rst) begin
            ov_prev_a = 1'b0;
        end else begin
            if (a_out_valid && !ov_prev_a) check("lat32", cyc - acc_cyc_a + 1, 9);
            ov_prev_a = a_out_valid;
            if (a_out_valid && a_out_ready) begin
                if (exp_a.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL out32: unexpected result count=%0d ge=%0b, none expected", a_out_count, a_out_ge);
                end else begin
                    e = exp_a.pop_front();
                    check("count32", 32'(a_out_count), 32'(e[6:1]));
                    check("ge32", 32'(a_out_ge), 32'(e[0]));
                end
            end
        end
    end

    // Monitor for the 4-bit instance
    always @(negedge clk) begin
        logic [3:0] e;
        if (rst) begin
            ov_prev_b = 1'b0;
        end else begin
            if (b_out_valid && !ov_prev_b) check("lat4", cyc - acc_cyc_b + 1, 2);
            ov_prev_b = b_out_valid;
            if (b_out_valid && b_out_ready) begin
                if (exp_b.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL out4: unexpected result count=%0d ge=%0b, none expected", b_out_count, b_out_ge);
                end else begin
                    e = exp_b.pop_front();
                    check("count4", 32'(b_out_count), 32'(e[3:1]));
                    check("ge4", 32'(b_out_ge), 32'(e[0]));
                end
            end
        end
    end

    // Drivers: called at posedge+1, return at posedge+1 after the accepting edge.
    task automatic send_a(input logic [31:0] d, input logic m, input logic [5:0] t,
                          input bit push, input int cnt, input bit ge);
        bit got = 1'b0;
        a_in_data   = d;
        a_in_mode   = m;
        a_in_thresh = t;
        a_in_valid  = 1'b1;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (a_in_ready) got = 1'b1;
        end
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        if (got) begin
            acc_cyc_a = cyc;
            if (push) exp_a.push_back({cnt[5:0], ge});
        end else begin
            n_vec++;
            n_miss++;
            $display("FAIL accept32: in_ready stayed 0, expected a word to be accepted");
        end
    endtask

    task automatic send_b(input logic [3:0] d, input logic m, input logic [2:0] t,
                          input int cnt, input bit ge);
        bit got = 1'b0;
        b_in_data   = d;
        b_in_mode   = m;
        b_in_thresh = t;
        b_in_valid  = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (b_in_ready) got = 1'b1;
        end
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        if (got) begin
            acc_cyc_b = cyc;
            exp_b.push_back({cnt[2:0], ge});
        end else begin
            n_vec++;
            n_miss++;
            $display("FAIL accept4: in_ready stayed 0, expected a word to be accepted");
        end
    endtask

    task automatic wait_idle_a();
        int k = 0;
        while (k < 200 && (exp_a.size() != 0 || a_busy)) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            n_vec++;
            n_miss++;
            $display("FAIL idle32: %0d results outstanding after timeout, expected 0", exp_a.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle_b();
        int k = 0;
        while (k < 50 && (exp_b.size() != 0 || b_busy)) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) begin
            n_vec++;
            n_miss++;
            $display("FAIL idle4: %0d results outstanding after timeout, expected 0", exp_b.size());
        end
        @(posedge clk);
        #1;
    endtask

    int ones_tab [16] = '{0, 1, 1, 2, 1, 2, 2, 3, 1, 2, 2, 3, 2, 3, 3, 4};

    initial begin
        rst         = 1'b1;
        a_in_valid  = 1'b0; a_in_data = '0; a_in_mode = 1'b0; a_in_thresh = '0; a_out_ready = 1'b1;
        b_in_valid  = 1'b0; b_in_data = '0; b_in_mode = 1'b0; b_in_thresh = '0; b_out_ready = 1'b1;
        stream_done = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(a_in_ready), 0);
        check("rst_out_valid", 32'(a_out_valid), 0);
        check("rst_busy", 32'(a_busy), 0);
        check("rst_count", 32'(a_out_count), 0);
        check("rst_ge", 32'(a_out_ge), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready32", 32'(a_in_ready), 1);
        check("post_rst_in_ready4", 32'(b_in_ready), 1);
        @(posedge clk);
        #1;

        // All zeros, thr 0 -> ge always 1; busy/in_ready while running
        send_a(32'h0000_0000, 1'b0, 6'd0, 1'b1, 0, 1'b1);
        check("run_busy", 32'(a_busy), 1);
        check("run_in_ready", 32'(a_in_ready), 0);
        wait_idle_a();

        // Directed vectors, back to back
        send_a(32'hFFFF_FFFF, 1'b0, 6'd33, 1'b1, 32, 1'b0);
        send_a(32'h0000_000F, 1'b1, 6'd28, 1'b1, 28, 1'b1);
        send_a(32'h1234_5678, 1'b0, 6'd13, 1'b1, 13, 1'b1);
        send_a(32'h8000_0001, 1'b1, 6'd31, 1'b1, 30, 1'b0);
        send_a(32'hFFFF_FFFF, 1'b0, 6'd63, 1'b1, 32, 1'b0);
        send_a(32'h0000_0000, 1'b1, 6'd32, 1'b1, 32, 1'b1);
        wait_idle_a();

        // Back-pressure: result must hold and new words must be refused
        a_out_ready = 1'b0;
        send_a(32'hA5A5_F00F, 1'b0, 6'd16, 1'b1, 16, 1'b1);
        begin
            int k = 0;
            while (k < 20 && !a_out_valid) begin
                @(negedge clk);
                k++;
            end
        end
        @(posedge clk);
        #1;
        a_in_valid = 1'b1;
        a_in_data  = 32'hFFFF_FFFF;
        a_in_mode  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(a_out_valid), 1);
            check("hold_count", 32'(a_out_count), 16);
            check("hold_ge", 32'(a_out_ge), 1);
            check("hold_in_ready", 32'(a_in_ready), 0);
        end
        @(posedge clk);
        #1;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        wait_idle_a();

        // Reset in the 4th RUN cycle discards the word
        send_a(32'hFFFF_0000, 1'b0, 6'd5, 1'b0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 32'(a_in_ready), 0);
        check("midrst_out_valid", 32'(a_out_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("after_rst_in_ready", 32'(a_in_ready), 1);
        check("after_rst_out_valid", 32'(a_out_valid), 0);
        check("after_rst_count", 32'(a_out_count), 0);
        check("after_rst_ge", 32'(a_out_ge), 0);
        check("after_rst_busy", 32'(a_busy), 0);
        repeat (12) @(negedge clk);
        @(posedge clk);
        #1;
        send_a(32'h0F0F_0F0F, 1'b0, 6'd17, 1'b1, 16, 1'b0);
        wait_idle_a();

        // Random stream with gaps and random back-pressure
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    logic [31:0] d;
                    logic        m;
                    logic [5:0]  t;
                    int          c;
                    int          gap;
                    d   = $urandom;
                    m   = 1'($urandom_range(0, 1));
                    t   = 6'($urandom_range(0, 40));
                    c   = $countones(m ? ~d : d);
                    gap = $urandom_range(0, 3);
                    for (int g = 0; g < gap; g++) begin
                        @(posedge clk);
                        #1;
                    end
                    send_a(d, m, t, 1'b1, c, c >= int'(t));
                end
                wait_idle_a();
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk);
                    #1;
                    a_out_ready = 1'($urandom_range(0, 1));
                end
                a_out_ready = 1'b1;
            end
        join

        // WIDTH=4: every value in both modes, thresholds 0..7
        for (int mode = 0; mode < 2; mode++) begin
            for (int v = 0; v < 16; v++) begin
                int         c;
                logic [2:0] t;
                c = (mode != 0) ? 4 - ones_tab[v] : ones_tab[v];
                t = 3'((v * 3 + mode) % 8);
                send_b(4'(v), 1'(mode), t, c, c >= int'(t));
            end
        end
        wait_idle_b();

        check("leftover32", exp_a.size(), 0);
        check("leftover4", exp_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/popcount_seq.md
# popcount_seq

Parametrised, multi-cycle population-count engine and the generalised successor of the team's fixed 4-bit ones-counter. It accepts a WIDTH-bit word over a valid/ready handshake and counts either ones or zeros, one 4-bit nibble per cycle, using a nibble lookup sub-block. It returns the count together with a threshold-compare flag over a second valid/ready handshake. It serves as the bit-statistics stage ahead of the parity/weight checkers.

## Interface
Parameters:
- WIDTH, 32, input word width; must be a multiple of 4 and at least 4
- NIB (localparam), WIDTH/4, nibbles per word and the number of compute cycles
- CW (localparam), $clog2(WIDTH+1), count width; 6 for WIDTH=32

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input word offered
- in_ready  out  1  block can accept a word
- in_data  in  WIDTH  word to count
- in_mode  in  1  0 = count ones, 1 = count zeros
- in_thresh  in  CW  unsigned compare threshold
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- out_count  out  CW  number of counted bits
- out_ge  out  1  1 when out_count >= captured in_thresh (unsigned)
- busy  out  1  high in RUN or DONE

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1 while rst is low.
  - On in_valid && in_ready: capture shreg = in_mode ? ~in_data : in_data, capture thr = in_thresh, set acc = 0 and idx = 0, then go to RUN.
- RUN:
  - Every cycle: acc <= acc + lut(shreg[3:0]) (3-bit value, zero-extended to CW), shreg >>= 4, idx++.
  - When idx == NIB-1, the final add is written to out_count, out_ge <= (final sum >= thr), and the FSM goes to DONE.
- DONE:
  - out_valid = 1. out_count and out_ge are held stable until out_valid && out_ready, then the FSM goes to IDLE.
- in_valid outside IDLE is ignored, because in_ready = 0. The producer must hold the word.
- Arithmetic is unsigned. The accumulator never exceeds WIDTH, so no overflow or saturation logic exists.
- in_mode and in_thresh are sampled only at acceptance. Later changes have no effect on the word in flight.

## Timing
- Reset values: state = IDLE, out_valid = 0, out_count = 0, out_ge = 0, busy = 0, acc = 0, idx = 0. in_ready = 0 while rst = 1 and 1 on the first cycle after rst deasserts.
- Latency: acceptance edge at cycle 0, RUN during cycles 1..NIB, out_valid visible from cycle NIB+1. For WIDTH=32 that is cycle 9.
- Throughput: with out_ready tied high, one word per NIB+2 cycles. The result handshake edge returns to IDLE; the next accept follows on the next edge.
- There is no combinational path from in_valid to in_ready, or from out_ready to out_valid. in_ready and out_valid decode from state only, gated by rst.
- Reset mid-operation, in RUN or DONE: the word is discarded and no out_valid pulse occurs. The next cycle is IDLE with the reset values.
- Boundary cases:
  - WIDTH=4 gives NIB=1: one RUN cycle, then DONE.
  - thr = 0 gives out_ge = 1 always.
  - thr > WIDTH gives out_ge = 0 always.

## Structure
- The shared package popcount_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the LUT_W = 4 constant;
  - a function returning the count width for a given WIDTH.
- There is one sub-module, popcount_nib4: purely combinational, 4-bit input to 3-bit ones count. It is instantiated once and fed from shreg[3:0].

## Test plan
- WIDTH=32, in_data=0x00000000, mode 0, thr 0 -> out_count=0, out_ge=1, out_valid rises 9 cycles after accept.
- in_data=0xFFFFFFFF, mode 0, thr 33 -> out_count=32, out_ge=0. Then in_data=0x0000000F, mode 1, thr 28 -> out_count=28, out_ge=1.
- in_data=0xA5A5F00F, mode 0, thr 16; out_ready held low for 5 cycles -> out_count=16, out_ge=1 held stable, in_ready=0 throughout, new in_valid ignored.
- Assert rst in the 4th RUN cycle of in_data=0xFFFF0000 -> no out_valid, out_count=0, in_ready=1 on the first cycle after rst deasserts, next word counted correctly.
- WIDTH=4 instance: all 16 values in both modes -> count matches the reference popcount, 2-cycle latency.
- Back-to-back stream of 100 random words with random out_ready and in_valid gaps -> every result matches the model and arrives in order, with no drop or duplicate.
